ocp_master_port: RTL and testbench
==================================

// Module: ocp_master_port
// PURPOSE
//  OCP initiator (master) end of the single-beat OCP read/write protocol that the RAM model and other slaves serve.
//  Converts a simple core-side request/done handshake into OCP MCmd/SCmdAccept/SResp transactions.
//  Adds a response-timeout watchdog so a dead slave cannot hang the core.
//  Sits between a CPU load/store or fetch unit and the system bus.
// PARAMETERS
//  TIMEOUT   255   max cycles spent in CMD+RESP before abort; 0 disables watchdog
//  ERR_DATA  32'hDEADDEAD   o_rdata value returned on timeout or error response
// PORTS
//  clk           in   1            clock, all state on posedge
//  nrst          in   1            reset, asynchronous, active-low
//  i_req         in   1            core request valid
//  i_rnw         in   1            1=read, 0=write
//  i_addr        in   ADDR_WIDTH   byte address
//  i_wdata       in   DATA_WIDTH   write data
//  i_ben         in   BEN_WIDTH    byte enables
//  o_ready       out  1            port can accept a request (state==IDLE)
//  o_done        out  1            one-cycle completion pulse
//  o_rdata       out  DATA_WIDTH   read data, valid with o_done
//  o_err         out  1            completion was ERR/FAIL/timeout, valid with o_done
//  o_MAddr       out  ADDR_WIDTH   OCP address
//  o_MCmd        out  3            OCP command (IDLE/WRITE/READ)
//  o_MData       out  DATA_WIDTH   OCP write data
//  o_MByteEn     out  BEN_WIDTH    OCP byte enables
//  i_SCmdAccept  in   1            slave accepted command
//  i_SData       in   DATA_WIDTH   slave read data
//  i_SResp       in   2            slave response (NULL/DVA/FAIL/ERR)
// BEHAVIOUR
//  - Reset: state IDLE; o_MCmd=OCP_CMD_IDLE; o_MAddr/o_MData/o_MByteEn=0; o_done=0; o_err=0; o_rdata=0; counter=0.
//  - nrst low mid-transaction: immediate abort to IDLE, o_MCmd IDLE, no o_done pulse.
//  - FSM one-hot 3-bit: IDLE=001, CMD=010, RESP=100. All OCP outputs and o_done/o_rdata/o_err registered.
//  - IDLE: o_ready=1 (combinational from state). i_req sampled high at edge -> latch addr/wdata/ben/rnw,
//    drive o_MCmd=READ (i_rnw=1) or WRITE, go CMD, clear counter. i_req ignored outside IDLE.
//  - CMD: o_MCmd and M* fields held stable until i_SCmdAccept sampled 1. On accept: o_MCmd<=IDLE;
//    if i_SResp!=NULL same edge -> complete directly (zero-latency slave), else go RESP.
//  - RESP: o_MCmd=IDLE; wait for i_SResp!=NULL. DVA -> o_done=1, o_err=0, o_rdata=i_SData (read) or
//    unchanged (write). FAIL/ERR -> o_done=1, o_err=1, o_rdata=ERR_DATA. Then IDLE.
//  - i_SResp!=NULL while in IDLE or CMD without accept: ignored (spurious).
//  - Watchdog: counter increments each cycle in CMD/RESP; reaching TIMEOUT -> o_MCmd=IDLE, o_done=1,
//    o_err=1, o_rdata=ERR_DATA, state IDLE. Completion and timeout on the same edge: completion wins.
//    Counter width $clog2(TIMEOUT+1), saturates, never wraps.
//  - o_done is high for exactly one cycle, coincident with the return to IDLE; o_ready is already 1 in
//    that cycle, so back-to-back requests are accepted. Minimum throughput vs. RAM model: 3 cycles/txn.
//  - Write data is never modified; byte enables are passed through unchanged for reads and writes.
// STRUCTURE
//  - OCP_CMD_* / OCP_RESP_* from ocp_const.vh (add OCP_RESP_FAIL, OCP_RESP_ERR there if missing);
//    ADDR_WIDTH/DATA_WIDTH/BEN_WIDTH from common.vh. State encodings are localparams.
//  - No sub-module; watchdog counter inline. Single file, target 150-250 lines.
// TESTING (bench pairs block with the RAM model, plus a scripted slave for error cases)
//  1. Reset: nrst=0 -> o_MCmd=IDLE, o_ready=1, o_done=0, o_rdata=0 while held and after release.
//  2. Write 32'hCAFEBABE to 0x100, ben=4'b1111, then read 0x100 -> o_done after 3 cycles each,
//     o_err=0, o_rdata=32'hCAFEBABE.
//  3. Partial write ben=4'b0010 data 32'h0000AB00 over 32'h11223344 at 0x104, read back -> 32'h1122AB44.
//  4. Scripted slave holds SCmdAccept=0 for 5 cycles -> o_MCmd and MAddr stable for 6 cycles; accept with
//     same-edge SResp=DVA, SData=32'h5A5A5A5A -> o_done next cycle, rdata=32'h5A5A5A5A.
//  5. TIMEOUT=8, slave never responds -> o_done=1, o_err=1, o_rdata=32'hDEADDEAD 8 cycles after CMD entry.
//  6. Slave returns SResp=ERR -> o_err=1; nrst pulsed in RESP of next txn -> no o_done, MCmd=IDLE at once.

Source files
------------

// File: rtl/ocp_master_port_pkg.sv
// OCP master port shared types: bus widths, OCP command/response codes,
// and the one-hot FSM encoding used by ocp_master_port.
package ocp_master_port_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  localparam int ST_IDLE_B = 0;
  localparam int ST_CMD_B  = 1;
  localparam int ST_RESP_B = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_CMD  = 3'b010,
    ST_RESP = 3'b100
  } state_e;

  function automatic logic [2:0] cmd_of(
    input logic rnw
  );
    return rnw ? OCP_CMD_READ : OCP_CMD_WRITE;
  endfunction

endpackage

// File: rtl/ocp_master_port.sv
// OCP initiator: core req/done handshake -> single-beat OCP MCmd/SCmdAccept/SResp.
// Ports: core side i_req/i_rnw/i_addr/i_wdata/i_ben -> o_ready/o_done/o_rdata/o_err;
//        bus side o_MCmd/o_MAddr/o_MData/o_MByteEn <- i_SCmdAccept/i_SData/i_SResp.
module ocp_master_port
  import ocp_master_port_pkg::*;
#(
  parameter int unsigned               TIMEOUT  = 255,
  parameter logic [DATA_WIDTH-1:0]     ERR_DATA = 32'hDEADDEAD
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_req,
  input  logic                  i_rnw,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [BEN_WIDTH-1:0]  i_ben,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int CW    = WD_EN ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] TO_LAST =
    WD_EN ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] TO_MAX =
    WD_EN ? CW'(TIMEOUT) : '0;

  state_e                state_q, state_d;
  logic [2:0]            mcmd_q, mcmd_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [BEN_WIDTH-1:0]  mben_q, mben_d;
  logic                  rnw_q, rnw_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  resp_vld;
  logic                  to_hit;
  logic [CW-1:0]         cnt_inc;
  logic                  fin;
  logic                  abort;

  assign resp_vld = (i_SResp != OCP_RESP_NULL);
  assign to_hit   = WD_EN && (cnt_q == TO_LAST);
  assign cnt_inc  = (cnt_q == TO_MAX) ? cnt_q
                                      : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    mcmd_d  = mcmd_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mben_d  = mben_q;
    rnw_d   = rnw_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    abort   = 1'b0;

    unique case (1'b1)
      state_q[ST_IDLE_B]: begin
        if (i_req) begin
          maddr_d = i_addr;
          mdata_d = i_wdata;
          mben_d  = i_ben;
          rnw_d   = i_rnw;
          mcmd_d  = cmd_of(i_rnw);
          cnt_d   = '0;
          state_d = ST_CMD;
        end
      end
      state_q[ST_CMD_B]: begin
        cnt_d = cnt_inc;
        if (i_SCmdAccept) begin
          mcmd_d = OCP_CMD_IDLE;
          // zero-latency slave: response on the accept edge
          if (resp_vld) fin = 1'b1;
          else state_d = ST_RESP;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
      state_q[ST_RESP_B]: begin
        cnt_d = cnt_inc;
        if (resp_vld) fin = 1'b1;
        else if (to_hit) abort = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        mcmd_d  = OCP_CMD_IDLE;
      end
    endcase

    // completion takes priority over a same-edge timeout
    if (fin) begin
      state_d = ST_IDLE;
      mcmd_d  = OCP_CMD_IDLE;
      done_d  = 1'b1;
      if (i_SResp == OCP_RESP_DVA) begin
        err_d = 1'b0;
        if (rnw_q) rdata_d = i_SData;
      end else begin
        err_d   = 1'b1;
        rdata_d = ERR_DATA;
      end
    end else if (abort) begin
      state_d = ST_IDLE;
      mcmd_d  = OCP_CMD_IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
      rdata_d = ERR_DATA;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      mcmd_q  <= OCP_CMD_IDLE;
      maddr_q <= '0;
      mdata_q <= '0;
      mben_q  <= '0;
      rnw_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcmd_q  <= mcmd_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mben_q  <= mben_d;
      rnw_q   <= rnw_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready   = state_q[ST_IDLE_B];
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_rdata   = rdata_q;
  assign o_MCmd    = mcmd_q;
  assign o_MAddr   = maddr_q;
  assign o_MData   = mdata_q;
  assign o_MByteEn = mben_q;

endmodule

// File: tb/tb_ocp_master_port.sv
// Bench for ocp_master_port: small RAM slave model for table vectors,
// scripted slave for stall, timeout, error and reset-abort sequences.
module tb_ocp_master_port;
  import ocp_master_port_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req, rnw;
  logic [31:0] addr, wdata;
  logic [3:0]  ben;
  logic        ready, done, err;
  logic [31:0] rdata, maddr, mdata;
  logic [2:0]  mcmd;
  logic [3:0]  mben;
  logic        s_acc;
  logic [31:0] s_data;
  logic [1:0]  s_resp;

  logic        mode;
  logic        sc_acc;
  logic [1:0]  sc_resp;
  logic [31:0] sc_data;
  logic [1:0]  ram_resp = OCP_RESP_NULL;
  logic [31:0] ram_data = '0;
  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ocp_master_port #(
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEADDEAD)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_req        (req),
    .i_rnw        (rnw),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_ben        (ben),
    .o_ready      (ready),
    .o_done       (done),
    .o_rdata      (rdata),
    .o_err        (err),
    .o_MAddr      (maddr),
    .o_MCmd       (mcmd),
    .o_MData      (mdata),
    .o_MByteEn    (mben),
    .i_SCmdAccept (s_acc),
    .i_SData      (s_data),
    .i_SResp      (s_resp)
  );

  always_comb begin
    s_acc  = mode ? sc_acc  : (mcmd != OCP_CMD_IDLE);
    s_resp = mode ? sc_resp : ram_resp;
    s_data = mode ? sc_data : ram_data;
  end

  // RAM model: accepts at once, DVA one cycle later
  always @(posedge clk) begin
    ram_resp <= OCP_RESP_NULL;
    if (!mode && mcmd != OCP_CMD_IDLE) begin
      ram_resp <= OCP_RESP_DVA;
      if (mcmd == OCP_CMD_WRITE) begin
        for (int b = 0; b < 4; b++)
          if (mben[b])
            mem[maddr[7:2]][8*b +: 8] <= mdata[8*b +: 8];
      end else begin
        ram_data <= mem[maddr[7:2]];
      end
    end
  end

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // starts at a negedge, ends at the negedge where o_done is seen
  task automatic run_vec(input vec_t v);
    int lat;
    logic [2:0] ecmd;
    ecmd  = v.rnw ? OCP_CMD_READ : OCP_CMD_WRITE;
    chk("ready_before_req", 32'(ready), 32'd1);
    req   = 1'b1;
    rnw   = v.rnw;
    addr  = v.addr;
    wdata = v.wdata;
    ben   = v.ben;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    chk("mcmd", 32'(mcmd), 32'(ecmd));
    chk("maddr", maddr, v.addr);
    chk("mbyteen", 32'(mben), 32'(v.ben));
    if (!v.rnw) chk("mdata", mdata, v.wdata);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    chk("err", 32'(err), 32'd0);
    chk("rdata", rdata, v.exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench hung");
  end

  initial begin
    int lat;
    tbl[0] = '{1'b0, 32'h100, 32'hCAFEBABE, 4'hF, 32'h0};
    tbl[1] = '{1'b1, 32'h100, 32'h0, 4'hF, 32'hCAFEBABE};
    tbl[2] = '{1'b0, 32'h104, 32'h11223344, 4'hF, 32'hCAFEBABE};
    tbl[3] = '{1'b0, 32'h104, 32'h0000AB00, 4'h2, 32'hCAFEBABE};
    tbl[4] = '{1'b1, 32'h104, 32'h0, 4'hF, 32'h1122AB44};
    tbl[5] = '{1'b0, 32'h108, 32'hFFFFFFFF, 4'hF, 32'h1122AB44};
    tbl[6] = '{1'b0, 32'h108, 32'hAABBCCDD, 4'h9, 32'h1122AB44};
    tbl[7] = '{1'b1, 32'h108, 32'h0, 4'h1, 32'hAAFFFFDD};
    tbl[8] = '{1'b1, 32'h100, 32'h0, 4'h6, 32'hCAFEBABE};

    nrst = 1'b0;
    req = 1'b0; rnw = 1'b0;
    addr = '0; wdata = '0; ben = '0;
    mode = 1'b0;
    sc_acc = 1'b0; sc_resp = OCP_RESP_NULL; sc_data = '0;

    // reset held
    @(negedge clk);
    @(negedge clk);
    chk("rst_mcmd", 32'(mcmd), 32'(OCP_CMD_IDLE));
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_mcmd", 32'(mcmd), 32'(OCP_CMD_IDLE));
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_rdata", rdata, 32'd0);

    // back-to-back RAM transactions
    for (int i = 0; i < 9; i++) run_vec(tbl[i]);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    // spurious response while idle
    mode = 1'b1;
    sc_resp = OCP_RESP_DVA;
    @(negedge clk);
    chk("spur_idle_done", 32'(done), 32'd0);
    chk("spur_idle_ready", 32'(ready), 32'd1);
    sc_resp = OCP_RESP_NULL;

    // stalled accept, spurious ERR before accept, same-edge DVA
    req = 1'b1; rnw = 1'b1;
    addr = 32'h200; ben = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req = 1'b0;
      chk("stall_mcmd", 32'(mcmd), 32'(OCP_CMD_READ));
      chk("stall_maddr", maddr, 32'h200);
      chk("stall_done", 32'(done), 32'd0);
      sc_resp = (i <= 5) ? OCP_RESP_ERR : OCP_RESP_DVA;
      if (i == 6) begin
        sc_acc  = 1'b1;
        sc_data = 32'h5A5A5A5A;
      end
    end
    @(negedge clk);
    sc_acc = 1'b0; sc_resp = OCP_RESP_NULL;
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_err", 32'(err), 32'd0);
    chk("zl_rdata", rdata, 32'h5A5A5A5A);
    chk("zl_mcmd", 32'(mcmd), 32'(OCP_CMD_IDLE));

    // watchdog: slave never accepts
    req = 1'b1; rnw = 1'b0;
    addr = 32'h300; wdata = 32'h1; ben = 4'h3;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req = 1'b0;
      if (lat == 8)
        chk("to_mcmd_held", 32'(mcmd), 32'(OCP_CMD_WRITE));
    end while (!done && lat < 20);
    chk("to_latency", 32'(lat), 32'd9);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", rdata, 32'hDEADDEAD);
    chk("to_mcmd", 32'(mcmd), 32'(OCP_CMD_IDLE));

    // completion on the timeout edge wins
    req = 1'b1; rnw = 1'b1;
    addr = 32'h304; ben = 4'hF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req = 1'b0;
      if (lat == 8) begin
        sc_acc  = 1'b1;
        sc_resp = OCP_RESP_DVA;
        sc_data = 32'h12345678;
      end
    end while (!done && lat < 20);
    sc_acc = 1'b0; sc_resp = OCP_RESP_NULL;
    chk("race_latency", 32'(lat), 32'd9);
    chk("race_err", 32'(err), 32'd0);
    chk("race_rdata", rdata, 32'h12345678);

    // ERR response from RESP state
    req = 1'b1; rnw = 1'b1; addr = 32'h400;
    @(negedge clk);
    req = 1'b0;
    sc_acc = 1'b1;
    @(negedge clk);
    sc_acc = 1'b0;
    chk("err_resp_mcmd", 32'(mcmd), 32'(OCP_CMD_IDLE));
    chk("err_resp_done0", 32'(done), 32'd0);
    sc_resp = OCP_RESP_ERR;
    @(negedge clk);
    sc_resp = OCP_RESP_NULL;
    chk("err_done", 32'(done), 32'd1);
    chk("err_err", 32'(err), 32'd1);
    chk("err_rdata", rdata, 32'hDEADDEAD);

    // reset while waiting in RESP
    req = 1'b1; rnw = 1'b1; addr = 32'h404;
    @(negedge clk);
    req = 1'b0;
    sc_acc = 1'b1;
    @(negedge clk);
    sc_acc = 1'b0;
    chk("abort_pre_ready", 32'(ready), 32'd0);
    nrst = 1'b0;
    #1;
    chk("abort_mcmd", 32'(mcmd), 32'(OCP_CMD_IDLE));
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    chk("abort_done_held", 32'(done), 32'd0);
    nrst = 1'b1;
    sc_resp = OCP_RESP_DVA;
    @(negedge clk);
    sc_resp = OCP_RESP_NULL;
    chk("abort_late_resp", 32'(done), 32'd0);
    chk("abort_idle", 32'(ready), 32'd1);

    // port still works after the abort
    mode = 1'b0;
    run_vec('{1'b1, 32'h104, 32'h0, 4'hF, 32'h1122AB44});

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
